// File: rtl/axis_depacketizer_pkg.sv
// Shared types for the receive-side depacketizer.
package axis_depacketizer_pkg;

  typedef enum logic [1:0] {
    PASS = 2'd0,
    DROP = 2'd1,
    PAD  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI-Stream register slice: registered valid/data downstream, registered ready upstream.
module axis_skid_buffer #(
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  aclk,
  input  logic                  aresetn,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready
);

  logic [DATA_WIDTH-1:0] skid_data;
  logic                  skid_valid;
  logic                  out_free;

  assign out_free      = !m_axis_tvalid || m_axis_tready;
  assign s_axis_tready = !skid_valid;

  // Skid entry catches the beat accepted while the output register is stalled.
  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      skid_valid    <= 1'b0;
      skid_data     <= '0;
    end else if (out_free) begin
      if (skid_valid) begin
        m_axis_tdata  <= skid_data;
        m_axis_tvalid <= 1'b1;
        skid_valid    <= 1'b0;
      end else if (s_axis_tvalid) begin
        m_axis_tdata  <= s_axis_tdata;
        m_axis_tvalid <= 1'b1;
      end else begin
        m_axis_tvalid <= 1'b0;
      end
    end else if (s_axis_tvalid && !skid_valid) begin
      skid_valid <= 1'b1;
      skid_data  <= s_axis_tdata;
    end
  end

endmodule

// File: rtl/axis_depacketizer.sv
// Strips tlast framing and forces each packet to a programmable beat count (truncate long, pad short),
// flagging start-of-packet on tuser and reporting per-packet length/error status.
module axis_depacketizer
  import axis_depacketizer_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH    = 16,
  parameter int unsigned           COUNTER_WIDTH = 16,
  parameter bit                    OPT_REGISTER  = 1'b0,
  parameter logic [DATA_WIDTH-1:0] PAD_VALUE     = '0
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [COUNTER_WIDTH-1:0] limit,
  input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  input  logic                     s_axis_tlast,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     m_axis_tuser,
  output logic                     stat_valid,
  output logic [COUNTER_WIDTH-1:0] stat_len,
  output logic                     stat_short,
  output logic                     stat_long
);

  localparam int unsigned   DW      = DATA_WIDTH;
  localparam int unsigned   CW      = COUNTER_WIDTH;
  localparam logic [CW-1:0] CNT_MAX = '1;

  state_t        state, state_nxt;
  logic [CW-1:0] in_cnt, in_nxt, out_cnt, out_nxt;
  logic [CW-1:0] int_limit, eff_limit, in_inc, len_nxt;
  logic          stat_fire, short_nxt, long_nxt;
  logic          first_beat, hold;
  logic [DW-1:0] core_tdata;
  logic          core_tvalid, core_tready, core_tuser;

  // The first beat of a packet sees the live limit; later beats use the copy latched at packet start.
  assign first_beat = (state == PASS) && (in_cnt == '0);
  assign eff_limit  = first_beat ? limit : int_limit;
  assign in_inc     = (in_cnt == CNT_MAX) ? CNT_MAX : in_cnt + CW'(1);
  // A one-beat packet right after a status pulse waits a cycle so pulses never abut.
  assign hold       = first_beat && stat_valid && s_axis_tlast;

  always_comb begin
    state_nxt     = state;
    in_nxt        = in_cnt;
    out_nxt       = out_cnt;
    stat_fire     = 1'b0;
    len_nxt       = in_inc;
    short_nxt     = 1'b0;
    long_nxt      = 1'b0;
    s_axis_tready = 1'b0;
    core_tvalid   = 1'b0;
    core_tdata    = s_axis_tdata;
    core_tuser    = 1'b0;
    unique case (state)
      PASS: begin
        s_axis_tready = core_tready && !hold;
        core_tvalid   = s_axis_tvalid && !hold;
        core_tuser    = (in_cnt == '0);
        if (s_axis_tvalid && core_tready && !hold) begin
          in_nxt = in_inc;
          if (s_axis_tlast) begin
            stat_fire = 1'b1;
            in_nxt    = '0;
            if (eff_limit != '0 && in_inc != eff_limit) begin
              short_nxt = 1'b1;
              out_nxt   = in_inc;
              state_nxt = PAD;
            end
          end else if (eff_limit != '0 && in_inc == eff_limit) begin
            state_nxt = DROP;
          end
        end
      end
      DROP: begin
        s_axis_tready = 1'b1;
        if (s_axis_tvalid) begin
          in_nxt = in_inc;
          if (s_axis_tlast) begin
            stat_fire = 1'b1;
            long_nxt  = 1'b1;
            in_nxt    = '0;
            state_nxt = PASS;
          end
        end
      end
      PAD: begin
        core_tvalid = 1'b1;
        core_tdata  = PAD_VALUE;
        if (core_tready) begin
          if (out_cnt + CW'(1) == int_limit) begin
            out_nxt   = '0;
            in_nxt    = '0;
            state_nxt = PASS;
          end else begin
            out_nxt = out_cnt + CW'(1);
          end
        end
      end
      default: state_nxt = PASS;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state      <= PASS;
      in_cnt     <= '0;
      out_cnt    <= '0;
      int_limit  <= '0;
      stat_valid <= 1'b0;
      stat_len   <= '0;
      stat_short <= 1'b0;
      stat_long  <= 1'b0;
    end else begin
      state      <= state_nxt;
      in_cnt     <= in_nxt;
      out_cnt    <= out_nxt;
      stat_valid <= stat_fire;
      if (first_beat) int_limit <= limit;
      if (stat_fire) begin
        stat_len   <= len_nxt;
        stat_short <= short_nxt;
        stat_long  <= long_nxt;
      end
    end
  end

  // Output stage: direct wiring, or a register slice carrying {tdata, tuser}.
  if (OPT_REGISTER) begin : g_reg
    logic [DW:0] skid_out;
    axis_skid_buffer #(.DATA_WIDTH(DW + 1)) u_skid (
      .aclk          (aclk),
      .aresetn       (aresetn),
      .s_axis_tdata  ({core_tdata, core_tuser}),
      .s_axis_tvalid (core_tvalid),
      .s_axis_tready (core_tready),
      .m_axis_tdata  (skid_out),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready)
    );
    assign m_axis_tdata = skid_out[DW:1];
    assign m_axis_tuser = skid_out[0];
  end else begin : g_comb
    assign core_tready   = m_axis_tready;
    assign m_axis_tdata  = core_tdata;
    assign m_axis_tvalid = core_tvalid;
    assign m_axis_tuser  = core_tuser;
  end

`ifdef FORMAL
  assert property (@(posedge aclk) disable iff (!aresetn) (state != PAD) |-> (out_cnt == '0));
  assert property (@(posedge aclk) disable iff (!aresetn)
    (m_axis_tvalid && !m_axis_tready) |=> (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tuser)));
`endif

endmodule

// File: tb/tb_axis_depacketizer.sv
// Directed bench for axis_depacketizer: runs the same sequence against the combinational and
// registered output variants, checking beats, tuser, status and AXI hold behaviour.
module tb_axis_depacketizer;

  localparam int unsigned DW = 16;
  localparam int unsigned CW = 16;
  localparam logic [DW-1:0] PADV = 16'h00EE;

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic [CW-1:0] limit = 16'd4;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          m_tready = 1'b1;
  logic          sel = 1'b0;
  logic          rnd = 1'b0;

  logic          c_str, c_mtv, c_mtu, c_sv, c_ss, c_slg;
  logic [DW-1:0] c_mtd;
  logic [CW-1:0] c_sl;
  logic          r_str, r_mtv, r_mtu, r_sv, r_ss, r_slg;
  logic [DW-1:0] r_mtd;
  logic [CW-1:0] r_sl;

  logic          a_str, a_mtv, a_mtu, a_sv, a_ss, a_slg;
  logic [DW-1:0] a_mtd;
  logic [CW-1:0] a_sl;

  int errors = 0;
  int checks = 0;

  logic [DW:0]   obs_q[$];
  logic [CW+1:0] stat_q[$];

  always #5 aclk = ~aclk;

  axis_depacketizer #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .OPT_REGISTER(1'b0), .PAD_VALUE(PADV)) u_comb (
    .aclk(aclk), .aresetn(aresetn), .limit(limit),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && !sel), .s_axis_tready(c_str), .s_axis_tlast(s_tlast),
    .m_axis_tdata(c_mtd), .m_axis_tvalid(c_mtv), .m_axis_tready(sel ? 1'b1 : m_tready), .m_axis_tuser(c_mtu),
    .stat_valid(c_sv), .stat_len(c_sl), .stat_short(c_ss), .stat_long(c_slg)
  );

  axis_depacketizer #(.DATA_WIDTH(DW), .COUNTER_WIDTH(CW), .OPT_REGISTER(1'b1), .PAD_VALUE(PADV)) u_reg (
    .aclk(aclk), .aresetn(aresetn), .limit(limit),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid && sel), .s_axis_tready(r_str), .s_axis_tlast(s_tlast),
    .m_axis_tdata(r_mtd), .m_axis_tvalid(r_mtv), .m_axis_tready(sel ? m_tready : 1'b1), .m_axis_tuser(r_mtu),
    .stat_valid(r_sv), .stat_len(r_sl), .stat_short(r_ss), .stat_long(r_slg)
  );

  assign a_str = sel ? r_str : c_str;
  assign a_mtv = sel ? r_mtv : c_mtv;
  assign a_mtu = sel ? r_mtu : c_mtu;
  assign a_mtd = sel ? r_mtd : c_mtd;
  assign a_sv  = sel ? r_sv  : c_sv;
  assign a_sl  = sel ? r_sl  : c_sl;
  assign a_ss  = sel ? r_ss  : c_ss;
  assign a_slg = sel ? r_slg : c_slg;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h (opt_register=%0d)", tag, got, exp, sel);
    end
  endtask

  always @(posedge aclk) begin
    #1;
    m_tready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Output/status capture plus hold-under-stall and pulse-spacing checks.
  logic          prev_v = 1'b0, prev_r = 1'b0, prev_rstn = 1'b0, prev_sv = 1'b0;
  logic [DW:0]   prev_d = '0;
  always @(negedge aclk) begin
    if (aresetn && a_mtv && m_tready) obs_q.push_back({a_mtu, a_mtd});
    if (a_sv) begin
      stat_q.push_back({a_ss, a_slg, a_sl});
      chk("stat_consecutive", 32'(prev_sv), 32'd0);
    end
    if (aresetn && prev_rstn && prev_v && !prev_r) begin
      chk("stall_valid_held", 32'(a_mtv), 32'd1);
      chk("stall_data_held", 32'({a_mtu, a_mtd}), 32'(prev_d));
    end
    prev_v    = a_mtv;
    prev_r    = m_tready;
    prev_rstn = aresetn;
    prev_sv   = a_sv;
    prev_d    = {a_mtu, a_mtd};
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    tick();
    aresetn = 1'b1;
  endtask

  task automatic clear();
    obs_q.delete();
    stat_q.delete();
  endtask

  task automatic put(input logic [DW-1:0] d, input logic last, output int stall);
    int   t  = 0;
    logic hs = 1'b0;
    s_tdata  = d;
    s_tlast  = last;
    s_tvalid = 1'b1;
    while (!hs && t < 200) begin
      @(negedge aclk);
      hs = a_str;
      tick();
      t++;
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    chk("input_handshake", 32'(hs), 32'd1);
    stall = t - 1;
    if (rnd) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic drain(input int n);
    int t = 0;
    while (obs_q.size() < n && t < 300) begin
      tick();
      t++;
    end
    repeat (6) tick();
  endtask

  task automatic exp_beat(input int idx, input logic user, input logic [DW-1:0] d);
    logic [DW:0] got;
    got = (idx < obs_q.size()) ? obs_q[idx] : {(DW+1){1'b1}};
    chk($sformatf("beat%0d", idx), 32'(got), 32'({user, d}));
  endtask

  task automatic exp_stat(input int idx, input logic sh, input logic lg, input logic [CW-1:0] len);
    logic [CW+1:0] got;
    got = (idx < stat_q.size()) ? stat_q[idx] : {(CW+2){1'b1}};
    chk($sformatf("stat%0d", idx), 32'(got), 32'({sh, lg, len}));
  endtask

  task automatic run_mode(input logic m);
    int st;
    int sum;
    sel = m; rnd = 1'b0; limit = 16'd4;
    do_reset();
    @(negedge aclk);
    chk("rst_m_tvalid", 32'(a_mtv), 32'd0);
    chk("rst_stat_valid", 32'(a_sv), 32'd0);
    chk("rst_stat_len", 32'(a_sl), 32'd0);
    chk("rst_s_tready", 32'(a_str), 32'd1);
    tick();

    // Exact-length packets pass 1:1.
    clear();
    for (int p = 0; p < 3; p++)
      for (int i = 0; i < 4; i++) put(DW'(32'h10 + p * 4 + i), i == 3, st);
    drain(12);
    chk("exact_count", 32'(obs_q.size()), 32'd12);
    for (int i = 0; i < 12; i++) exp_beat(i, (i % 4) == 0, DW'(32'h10 + i));
    chk("exact_stats", 32'(stat_q.size()), 32'd3);
    for (int k = 0; k < 3; k++) exp_stat(k, 1'b0, 1'b0, 16'd4);

    // Short packet padded, then long packet truncated.
    clear();
    put(16'h00A0, 1'b0, st);
    put(16'h00A1, 1'b1, st);
    put(16'h00B0, 1'b0, st);
    chk("pad_input_stall", 32'(st), 32'd2);
    for (int i = 1; i < 4; i++) put(DW'(32'hB0 + i), 1'b0, st);
    sum = 0;
    for (int i = 4; i < 7; i++) begin
      put(DW'(32'hB0 + i), i == 6, st);
      sum += st;
    end
    chk("drop_no_stall", 32'(sum), 32'd0);
    drain(8);
    chk("short_long_count", 32'(obs_q.size()), 32'd8);
    exp_beat(0, 1'b1, 16'h00A0); exp_beat(1, 1'b0, 16'h00A1);
    exp_beat(2, 1'b0, PADV);     exp_beat(3, 1'b0, PADV);
    exp_beat(4, 1'b1, 16'h00B0); exp_beat(5, 1'b0, 16'h00B1);
    exp_beat(6, 1'b0, 16'h00B2); exp_beat(7, 1'b0, 16'h00B3);
    chk("short_long_stats", 32'(stat_q.size()), 32'd2);
    exp_stat(0, 1'b1, 1'b0, 16'd2);
    exp_stat(1, 1'b0, 1'b1, 16'd7);

    // Random backpressure/gaps; limit changed mid-packet applies to the next packet only.
    clear();
    rnd = 1'b1;
    put(16'h00C0, 1'b0, st);
    limit = 16'd3;
    for (int i = 1; i < 5; i++) put(DW'(32'hC0 + i), i == 4, st);
    for (int i = 0; i < 3; i++) put(DW'(32'hD0 + i), i == 2, st);
    drain(7);
    rnd = 1'b0;
    repeat (4) tick();
    chk("rand_count", 32'(obs_q.size()), 32'd7);
    for (int i = 0; i < 4; i++) exp_beat(i, i == 0, DW'(32'hC0 + i));
    for (int i = 0; i < 3; i++) exp_beat(4 + i, i == 0, DW'(32'hD0 + i));
    chk("rand_stats", 32'(stat_q.size()), 32'd2);
    exp_stat(0, 1'b0, 1'b1, 16'd5);
    exp_stat(1, 1'b0, 1'b0, 16'd3);

    // Reset while padding.
    clear();
    limit = 16'd4;
    put(16'h00E0, 1'b1, st);
    tick();
    do_reset();
    @(negedge aclk);
    chk("rst_pad_m_tvalid", 32'(a_mtv), 32'd0);
    chk("rst_pad_stat_valid", 32'(a_sv), 32'd0);
    tick();
    drain(0);
    chk("rst_pad_count", 32'(obs_q.size()), m ? 32'd1 : 32'd2);
    exp_beat(0, 1'b1, 16'h00E0);
    if (!m) exp_beat(1, 1'b0, PADV);
    chk("rst_pad_stats", 32'(stat_q.size()), 32'd1);
    exp_stat(0, 1'b1, 1'b0, 16'd1);

    // Reset while dropping, then a normal packet.
    clear();
    limit = 16'd2;
    for (int i = 0; i < 3; i++) put(DW'(32'hF0 + i), 1'b0, st);
    do_reset();
    @(negedge aclk);
    chk("rst_drop_m_tvalid", 32'(a_mtv), 32'd0);
    chk("rst_drop_stat_valid", 32'(a_sv), 32'd0);
    chk("rst_drop_stat_len", 32'(a_sl), 32'd0);
    tick();
    put(16'h0090, 1'b0, st);
    put(16'h0091, 1'b1, st);
    drain(4);
    chk("rst_drop_count", 32'(obs_q.size()), 32'd4);
    exp_beat(0, 1'b1, 16'h00F0); exp_beat(1, 1'b0, 16'h00F1);
    exp_beat(2, 1'b1, 16'h0090); exp_beat(3, 1'b0, 16'h0091);
    chk("rst_drop_stats", 32'(stat_q.size()), 32'd1);
    exp_stat(0, 1'b0, 1'b0, 16'd2);

    // limit=0: pure pass-through with length reporting.
    clear();
    limit = 16'd0;
    for (int i = 0; i < 3; i++) put(DW'(32'h50 + i), i == 2, st);
    put(16'h0060, 1'b1, st);
    drain(4);
    chk("lim0_count", 32'(obs_q.size()), 32'd4);
    exp_beat(0, 1'b1, 16'h0050); exp_beat(1, 1'b0, 16'h0051);
    exp_beat(2, 1'b0, 16'h0052); exp_beat(3, 1'b1, 16'h0060);
    chk("lim0_stats", 32'(stat_q.size()), 32'd2);
    exp_stat(0, 1'b0, 1'b0, 16'd3);
    exp_stat(1, 1'b0, 1'b0, 16'd1);

    // limit=1: single-beat frames; longer packets drop after the first beat.
    clear();
    limit = 16'd1;
    put(16'h0070, 1'b1, st);
    for (int i = 0; i < 3; i++) put(DW'(32'h80 + i), i == 2, st);
    drain(2);
    chk("lim1_count", 32'(obs_q.size()), 32'd2);
    exp_beat(0, 1'b1, 16'h0070); exp_beat(1, 1'b1, 16'h0080);
    chk("lim1_stats", 32'(stat_q.size()), 32'd2);
    exp_stat(0, 1'b0, 1'b0, 16'd1);
    exp_stat(1, 1'b0, 1'b1, 16'd3);
  endtask

  initial begin
    run_mode(1'b0);
    run_mode(1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench did not complete");
  end

endmodule
